// File: rtl/eth_downlink_port.sv
// MAC RX receive port: buffers whole packets, drops bad/runt/overflowing ones,
// and replays committed packets in order to the ctrl, data or fwd stream by EtherType.
module eth_downlink_port #(
    parameter int          DEPTH      = 2048,
    parameter int          DESC_DEPTH = 16,
    parameter logic [15:0] CTRL_ETYPE = 16'h88B5,
    parameter logic [15:0] FWD_ETYPE  = 16'h88B6
) (
    input  logic        i_data_clk,
    input  logic        i_data_rst,
    input  logic        s_rx_axis_tvalid,
    input  logic [63:0] s_rx_axis_tdata,
    input  logic        s_rx_axis_tlast,
    input  logic [7:0]  s_rx_axis_tkeep,
    input  logic        s_rx_axis_tuser,
    output logic        m_ctrl_axis_tvalid,
    output logic [63:0] m_ctrl_axis_tdata,
    output logic        m_ctrl_axis_tlast,
    output logic [7:0]  m_ctrl_axis_tkeep,
    output logic        m_ctrl_axis_tuser,
    output logic        m_data_axis_tvalid,
    output logic [63:0] m_data_axis_tdata,
    output logic        m_data_axis_tlast,
    output logic [7:0]  m_data_axis_tkeep,
    output logic        m_data_axis_tuser,
    input  logic        m_data_axis_tready,
    output logic        m_fwd_axis_tvalid,
    output logic [63:0] m_fwd_axis_tdata,
    output logic        m_fwd_axis_tlast,
    output logic [7:0]  m_fwd_axis_tkeep,
    output logic        m_fwd_axis_tuser,
    input  logic        m_fwd_axis_tready,
    output logic [15:0] o_rx_pkt_cnt,
    output logic [15:0] o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DESC_DEPTH);
    localparam logic [DW:0] DESC_FULL = DESC_DEPTH[DW:0];
    localparam logic [1:0] CLS_CTRL = 2'd0, CLS_DATA = 2'd1, CLS_FWD = 2'd2;

    typedef enum logic [1:0] {W_SYNC, W_IDLE, W_BODY, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;

    function automatic logic [1:0] classify(input logic [63:0] d);
        logic [15:0] et;
        et = {d[39:32], d[47:40]};
        if (et == CTRL_ETYPE) return CLS_CTRL;
        if (et == FWD_ETYPE)  return CLS_FWD;
        return CLS_DATA;
    endfunction

    logic [72:0]   mem [DEPTH];
    logic [AW+2:0] dq_mem [DESC_DEPTH];
    wstate_t       ws_q, ws_d;
    rstate_t       rs_q, rs_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d, end_q, end_d;
    logic          ovf_q, ovf_d, first_q, first_d;
    logic [1:0]    cls_q, cls_d, rcls_q, rcls_d, push_cls, issue_cls, rtag_q;
    logic [15:0]   rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [DW:0]   dq_wr_q, dq_rd_q, pend_q, pend_d;
    logic          wr_en, dq_push, dq_pop, rd_en, rvld_q, buf_full, desc_full, pop, room, head_rdy;
    logic [AW+2:0] dq_head;
    logic [72:0]   rdata_q;
    logic [74:0]   ob_q [2];
    logic [74:0]   ob_d [2];
    logic [1:0]    ocnt_q, ocnt_d, sub;
    logic [2:0]    occ;

    assign buf_full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign desc_full = (pend_q == DESC_FULL);
    assign dq_head   = dq_mem[dq_rd_q[DW-1:0]];

    always_comb begin
        ws_d = ws_q; wr_ptr_d = wr_ptr_q; wr_commit_d = wr_commit_q;
        ovf_d = ovf_q; first_d = first_q; cls_d = cls_q; push_cls = cls_q;
        wr_en = 1'b0; dq_push = 1'b0; rx_cnt_d = rx_cnt_q; drop_cnt_d = drop_cnt_q;
        case (ws_q)
            W_SYNC: if (!s_rx_axis_tvalid || s_rx_axis_tlast) ws_d = W_IDLE;
            W_IDLE: if (s_rx_axis_tvalid) begin
                if (s_rx_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end else if (desc_full) begin
                    ws_d = W_DROP;
                end else begin
                    ws_d = W_BODY; first_d = 1'b1; ovf_d = buf_full;
                    if (!buf_full) begin
                        wr_en = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            W_BODY: if (s_rx_axis_tvalid) begin
                if (first_q) begin
                    cls_d = classify(s_rx_axis_tdata); first_d = 1'b0;
                end
                if (!ovf_q && !buf_full) begin
                    wr_en = 1'b1; wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                if (s_rx_axis_tlast) begin
                    ws_d = W_IDLE;
                    if (s_rx_axis_tuser || ovf_q || buf_full) begin
                        wr_ptr_d = wr_commit_q; drop_cnt_d = drop_cnt_q + 16'd1;
                    end else begin
                        wr_commit_d = wr_ptr_q + 1'b1; dq_push = 1'b1;
                        push_cls = first_q ? classify(s_rx_axis_tdata) : cls_q;
                        rx_cnt_d = rx_cnt_q + 16'd1;
                    end
                end
            end
            W_DROP: if (s_rx_axis_tvalid && s_rx_axis_tlast) begin
                ws_d = W_IDLE; drop_cnt_d = drop_cnt_q + 16'd1;
            end
            default: ws_d = W_SYNC;
        endcase
    end

    // Output skid: a read is issued only if the 2-entry queue can absorb it next cycle.
    assign head_rdy = (ob_q[0][74:73] == CLS_CTRL) ||
                      (ob_q[0][74:73] == CLS_DATA && m_data_axis_tready) ||
                      (ob_q[0][74:73] == CLS_FWD && m_fwd_axis_tready);
    assign pop  = (ocnt_q != 2'd0) && head_rdy;
    assign occ  = {1'b0, ocnt_q} + {2'b0, rvld_q} - {2'b0, pop};
    assign room = (occ < 3'd2);
    assign sub  = ocnt_q - {1'b0, pop};

    always_comb begin
        rs_d = rs_q; rd_ptr_d = rd_ptr_q; end_d = end_q; rcls_d = rcls_q;
        rd_en = 1'b0; dq_pop = 1'b0; issue_cls = rcls_q;
        case (rs_q)
            R_IDLE: if (dq_rd_q != dq_wr_q) begin
                dq_pop = 1'b1; rs_d = R_SEND;
                rcls_d = dq_head[AW+2:AW+1]; end_d = dq_head[AW:0];
                issue_cls = dq_head[AW+2:AW+1];
                if (room) begin
                    rd_en = 1'b1; rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            R_SEND: if (room) begin
                rd_en = 1'b1; rd_ptr_d = rd_ptr_q + 1'b1;
                if (rd_ptr_q + 1'b1 == end_q) rs_d = R_IDLE;
            end
            default: rs_d = R_IDLE;
        endcase
    end

    always_comb begin
        ob_d[0] = ob_q[0]; ob_d[1] = ob_q[1];
        pend_d  = pend_q;
        ocnt_d  = ocnt_q + {1'b0, rvld_q} - {1'b0, pop};
        if (pop) ob_d[0] = ob_q[1];
        if (rvld_q) ob_d[sub[0]] = {rtag_q, rdata_q};
        case ({dq_push, pop && ob_q[0][72]})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge i_data_clk) begin
        if (i_data_rst) begin
            ws_q <= W_SYNC; rs_q <= R_IDLE;
            wr_ptr_q <= '0; wr_commit_q <= '0; rd_ptr_q <= '0; end_q <= '0;
            ovf_q <= 1'b0; first_q <= 1'b0; cls_q <= '0; rcls_q <= '0;
            rx_cnt_q <= '0; drop_cnt_q <= '0;
            dq_wr_q <= '0; dq_rd_q <= '0; pend_q <= '0;
            rvld_q <= 1'b0; ocnt_q <= '0; ob_q[0] <= '0; ob_q[1] <= '0;
        end else begin
            ws_q <= ws_d; rs_q <= rs_d;
            wr_ptr_q <= wr_ptr_d; wr_commit_q <= wr_commit_d; rd_ptr_q <= rd_ptr_d; end_q <= end_d;
            ovf_q <= ovf_d; first_q <= first_d; cls_q <= cls_d; rcls_q <= rcls_d;
            rx_cnt_q <= rx_cnt_d; drop_cnt_q <= drop_cnt_d;
            dq_wr_q <= dq_wr_q + {{DW{1'b0}}, dq_push};
            dq_rd_q <= dq_rd_q + {{DW{1'b0}}, dq_pop};
            pend_q <= pend_d;
            rvld_q <= rd_en; ocnt_q <= ocnt_d; ob_q[0] <= ob_d[0]; ob_q[1] <= ob_d[1];
        end
    end

    always_ff @(posedge i_data_clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_rx_axis_tlast, s_rx_axis_tkeep, s_rx_axis_tdata};
        if (dq_push) dq_mem[dq_wr_q[DW-1:0]] <= {push_cls, wr_commit_d};
        if (rd_en) begin
            rdata_q <= mem[rd_ptr_q[AW-1:0]];
            rtag_q  <= issue_cls;
        end
    end

    assign m_ctrl_axis_tvalid = (ocnt_q != 2'd0) && (ob_q[0][74:73] == CLS_CTRL);
    assign m_data_axis_tvalid = (ocnt_q != 2'd0) && (ob_q[0][74:73] == CLS_DATA);
    assign m_fwd_axis_tvalid  = (ocnt_q != 2'd0) && (ob_q[0][74:73] == CLS_FWD);
    assign m_ctrl_axis_tdata  = ob_q[0][63:0];
    assign m_data_axis_tdata  = ob_q[0][63:0];
    assign m_fwd_axis_tdata   = ob_q[0][63:0];
    assign m_ctrl_axis_tkeep  = ob_q[0][71:64];
    assign m_data_axis_tkeep  = ob_q[0][71:64];
    assign m_fwd_axis_tkeep   = ob_q[0][71:64];
    assign m_ctrl_axis_tlast  = ob_q[0][72];
    assign m_data_axis_tlast  = ob_q[0][72];
    assign m_fwd_axis_tlast   = ob_q[0][72];
    assign m_ctrl_axis_tuser  = 1'b0;
    assign m_data_axis_tuser  = 1'b0;
    assign m_fwd_axis_tuser   = 1'b0;
    assign o_rx_pkt_cnt       = rx_cnt_q;
    assign o_drop_cnt         = drop_cnt_q;
endmodule

// File: tb/tb_eth_downlink_port.sv
// Scoreboarded bench for eth_downlink_port: stimulus pushes expected beats per stream,
// a negedge monitor pops and compares accepted beats and checks AXIS stability.
module tb_eth_downlink_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        c_tvalid, c_tlast, c_tuser, d_tvalid, d_tlast, d_tuser, f_tvalid, f_tlast, f_tuser;
    logic [63:0] c_tdata, d_tdata, f_tdata;
    logic [7:0]  c_tkeep, d_tkeep, f_tkeep;
    logic        d_tready = 1'b1, f_tready = 1'b1;
    logic [15:0] rx_cnt, drop_cnt;

    always #5 clk = ~clk;

    eth_downlink_port #(.DEPTH(64)) dut (
        .i_data_clk(clk), .i_data_rst(rst),
        .s_rx_axis_tvalid(s_tvalid), .s_rx_axis_tdata(s_tdata), .s_rx_axis_tlast(s_tlast),
        .s_rx_axis_tkeep(s_tkeep), .s_rx_axis_tuser(s_tuser),
        .m_ctrl_axis_tvalid(c_tvalid), .m_ctrl_axis_tdata(c_tdata), .m_ctrl_axis_tlast(c_tlast),
        .m_ctrl_axis_tkeep(c_tkeep), .m_ctrl_axis_tuser(c_tuser),
        .m_data_axis_tvalid(d_tvalid), .m_data_axis_tdata(d_tdata), .m_data_axis_tlast(d_tlast),
        .m_data_axis_tkeep(d_tkeep), .m_data_axis_tuser(d_tuser), .m_data_axis_tready(d_tready),
        .m_fwd_axis_tvalid(f_tvalid), .m_fwd_axis_tdata(f_tdata), .m_fwd_axis_tlast(f_tlast),
        .m_fwd_axis_tkeep(f_tkeep), .m_fwd_axis_tuser(f_tuser), .m_fwd_axis_tready(f_tready),
        .o_rx_pkt_cnt(rx_cnt), .o_drop_cnt(drop_cnt)
    );

    typedef logic [72:0] beat_t;
    localparam int CTRL = 0, DATA = 1, FWD = 2;
    beat_t expq [3][$];
    int checks = 0, passes = 0;
    int drdy_mode = 1, frdy_mode = 1;
    logic [2:0] hold = '0;
    beat_t holdb [3];

    function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s got %h want %h", nm, act, exp);
    endfunction

    function automatic logic [63:0] mkdata(input int pid, input int i, input logic [15:0] et);
        logic [63:0] d;
        d = {pid[7:0], i[7:0], 16'hBEEF ^ i[15:0], pid[15:0], i[15:0]};
        if (i == 1) d[47:32] = {et[7:0], et[15:8]};
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic send_pkt(input int pid, input logic [15:0] et, input int nb, input logic [7:0] lk,
                            input logic bad, input logic expect_out, input int cls);
        logic [63:0] d;
        logic        last;
        logic [7:0]  k;
        for (int i = 0; i < nb; i++) begin
            d = mkdata(pid, i, et);
            last = (i == nb - 1);
            k = last ? lk : 8'hFF;
            tick();
            s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tkeep = k; s_tuser = last & bad;
            if (expect_out) expq[cls].push_back({last, k, d});
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 3000) begin
            tick();
            n++;
        end
        chk({"drain_", nm}, expq[0].size() + expq[1].size() + expq[2].size(), 0);
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        d_tready = (drdy_mode == 2) ? 1'($urandom_range(0, 1)) : (drdy_mode == 1);
        f_tready = (frdy_mode == 2) ? 1'($urandom_range(0, 1)) : (frdy_mode == 1);
    end

    always @(negedge clk) begin
        logic [2:0] vv, rr, uu;
        beat_t      bb [3];
        beat_t      e;
        vv = {f_tvalid, d_tvalid, c_tvalid};
        rr = {f_tready, d_tready, 1'b1};
        uu = {f_tuser, d_tuser, c_tuser};
        bb[0] = {c_tlast, c_tkeep, c_tdata};
        bb[1] = {d_tlast, d_tkeep, d_tdata};
        bb[2] = {f_tlast, f_tkeep, f_tdata};
        if (rst) begin
            for (int s = 0; s < 3; s++) expq[s].delete();
            hold = '0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (hold[s]) chk($sformatf("stable_s%0d", s), {vv[s], bb[s]}, {1'b1, holdb[s]});
                if (expq[s].size() == 0) begin
                    chk($sformatf("idle_valid_s%0d", s), vv[s], 1'b0);
                end else if (vv[s] && rr[s]) begin
                    e = expq[s].pop_front();
                    chk($sformatf("beat_s%0d", s), bb[s], e);
                    chk($sformatf("tuser_s%0d", s), uu[s], 1'b0);
                end
                hold[s] = vv[s] && !rr[s];
                holdb[s] = bb[s];
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) tick();
        chk("rst_ctrl", {c_tvalid, c_tlast, c_tkeep, c_tdata, c_tuser}, '0);
        chk("rst_data", {d_tvalid, d_tlast, d_tkeep, d_tdata, d_tuser}, '0);
        chk("rst_fwd", {f_tvalid, f_tlast, f_tkeep, f_tdata, f_tuser}, '0);
        chk("rst_cnts", {rx_cnt, drop_cnt}, '0);
        rst = 1'b0;
        repeat (2) tick();

        // Control packet with partial last beat, plus first-beat latency.
        send_pkt(1, 16'h88B5, 8, 8'h0F, 1'b0, 1'b1, CTRL);
        idle();
        lat = 0;
        while (!c_tvalid && lat < 8) begin
            tick();
            lat++;
        end
        chk("ctrl_latency_le4", lat <= 4, 1'b1);
        wait_drain("ctrl");
        chk("rx_after_ctrl", rx_cnt, 16'd1);
        chk("drop_after_ctrl", drop_cnt, 16'd0);

        // 64-beat data packet with random backpressure.
        drdy_mode = 2;
        send_pkt(2, 16'h0800, 64, 8'hFF, 1'b0, 1'b1, DATA);
        idle();
        wait_drain("data64");
        drdy_mode = 1;
        chk("rx_after_data", rx_cnt, 16'd2);

        // Bad FCS frame then a good one.
        send_pkt(3, 16'h0800, 5, 8'h03, 1'b1, 1'b0, DATA);
        send_pkt(4, 16'h0800, 5, 8'h01, 1'b0, 1'b1, DATA);
        idle();
        wait_drain("bad_good");
        chk("rx_after_bad", rx_cnt, 16'd3);
        chk("drop_after_bad", drop_cnt, 16'd1);

        // Buffer overflow on the forward stream.
        apply_reset();
        frdy_mode = 0;
        repeat (2) tick();
        for (int p = 0; p < 5; p++) send_pkt(10 + p, 16'h88B6, 16, 8'hFF, 1'b0, p < 4, FWD);
        idle();
        repeat (4) tick();
        chk("rx_after_ovf", rx_cnt, 16'd4);
        chk("drop_after_ovf", drop_cnt, 16'd1);
        frdy_mode = 1;
        wait_drain("ovf");

        // Descriptor queue full, then a runt.
        apply_reset();
        drdy_mode = 0;
        repeat (2) tick();
        for (int p = 0; p < 17; p++) send_pkt(20 + p, 16'h0800, 2, 8'h7F, 1'b0, p < 16, DATA);
        idle();
        repeat (4) tick();
        chk("rx_after_descfull", rx_cnt, 16'd16);
        chk("drop_after_descfull", drop_cnt, 16'd1);
        drdy_mode = 1;
        wait_drain("descfull");
        send_pkt(40, 16'h0800, 1, 8'hFF, 1'b0, 1'b0, DATA);
        idle();
        repeat (4) tick();
        chk("drop_after_runt", drop_cnt, 16'd2);
        chk("rx_after_runt", rx_cnt, 16'd16);

        // Reset while a fwd packet is stuck on the output and a data packet is arriving.
        apply_reset();
        frdy_mode = 0;
        repeat (2) tick();
        send_pkt(50, 16'h88B6, 4, 8'hFF, 1'b0, 1'b1, FWD);
        idle();
        repeat (8) tick();
        chk("fwd_held_valid", f_tvalid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            s_tvalid = 1'b1; s_tdata = mkdata(51, i, 16'h0800); s_tkeep = 8'hFF;
            s_tlast = (i == 5); s_tuser = 1'b0;
            if (i == 3) rst = 1'b1;
            if (i == 4) begin
                rst = 1'b0;
                chk("midrst_valids", {c_tvalid, d_tvalid, f_tvalid}, 3'b000);
                chk("midrst_cnts", {rx_cnt, drop_cnt}, '0);
            end
        end
        idle();
        frdy_mode = 1;
        repeat (3) tick();
        send_pkt(52, 16'h88B5, 3, 8'h3F, 1'b0, 1'b1, CTRL);
        idle();
        wait_drain("after_midrst");
        chk("rx_after_midrst", rx_cnt, 16'd1);
        chk("drop_after_midrst", drop_cnt, 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/eth_downlink_port.md
# eth_downlink_port

Receive-side counterpart of the uplink TX port. It accepts the 10G MAC RX AXI-Stream, which has no backpressure, and stores each packet in an internal buffer. Good packets are classified by EtherType and delivered in arrival order to one of three output streams: control, data or forward. A packet is dropped whole on a bad FCS (tuser), a runt, buffer overflow or a full descriptor queue. The block sits between the MAC RX and the switch logic, in the data clock domain.

## Interface
- DEPTH, 2048, packet buffer depth in 64-bit beats; must be a power of 2.
- DESC_DEPTH, 16, descriptor queue entries (committed packets awaiting readout); must be a power of 2.
- CTRL_ETYPE, 16'h88B5, EtherType routed to the control output.
- FWD_ETYPE, 16'h88B6, EtherType routed to the forward output; any other EtherType goes to the data output.
- i_data_clk  in  1  single clock for the whole block.
- i_data_rst  in  1  reset: synchronous, active-high.
- s_rx_axis_tvalid/tdata/tlast/tkeep/tuser  in  1/64/1/8/1  MAC RX stream, no tready. tuser=1 on the tlast beat marks a bad frame.
- m_ctrl_axis_tvalid/tdata/tlast/tkeep/tuser  out  1/64/1/8/1  control stream, no tready (consumer always accepts). tuser is always 0.
- m_data_axis_tvalid/tdata/tlast/tkeep/tuser  out  1/64/1/8/1  data stream. tuser is always 0.
- m_data_axis_tready  in  1  data stream backpressure.
- m_fwd_axis_tvalid/tdata/tlast/tkeep/tuser  out  1/64/1/8/1  forward stream. tuser is always 0.
- m_fwd_axis_tready  in  1  forward stream backpressure.
- o_rx_pkt_cnt  out  16  count of committed packets; wraps.
- o_drop_cnt  out  16  count of dropped packets; wraps.

## Operation
- Byte order:
  - tdata[7:0] is the first byte on the wire.
  - EtherType = {beat1.tdata[39:32], beat1.tdata[47:40]} (bytes 12 and 13).
- Buffer entry is {tlast, tkeep, tdata}, 73 bits.
- Pointers carry one extra wrap bit, so capacity is exactly DEPTH beats.
- Writer FSM has states SYNC, IDLE, BODY, DROP.
- SYNC (state after reset):
  - Discards input beats.
  - Goes to IDLE on any cycle with tvalid=0, or on an accepted tlast beat.
- IDLE, on a valid beat (start of packet):
  - If the descriptor queue is full: go to DROP (or count the drop immediately if the beat has tlast).
  - Otherwise write the beat at wr_ptr and go to BODY.
  - A single-beat packet (tlast on beat 0) is a runt: it is dropped and wr_ptr is not advanced.
- BODY:
  - Each beat is written and wr_ptr advances.
  - Beat 1 latches the class: CTRL=0, DATA=1, FWD=2.
  - If the buffer is full when a beat arrives: set the overflow flag and stop writing for the rest of the packet.
  - On tlast, if tuser=1 or overflow is set: rewind wr_ptr to wr_commit, increment o_drop_cnt, go to IDLE.
  - On tlast otherwise: wr_commit = wr_ptr+1, push the class onto the descriptor queue, increment o_rx_pkt_cnt, go to IDLE.
- DROP: discards beats until tlast, then increments o_drop_cnt and goes to IDLE.
- The reader only sees committed space. Full is computed from rd_ptr and wr_ptr; empty is computed from rd_ptr and wr_commit.
- Reader FSM has states IDLE and SEND.
  - IDLE: if the descriptor queue is non-empty, pop it, latch the class, go to SEND.
  - SEND: stream the buffer head to the selected output. A beat is consumed on tvalid&tready (ctrl tready is implicitly 1). The beat with tlast accepted returns the reader to IDLE.
- Delivery is strictly in order through one buffer. A stalled output blocks every packet behind it (head-of-line blocking is accepted).
- Non-selected outputs hold tvalid=0. tdata/tkeep/tlast on an inactive output are don't-care.
- Simultaneous events:
  - Commit and pop in the same cycle are both honoured.
  - Buffer space freed in a cycle becomes visible to the writer in the next cycle.

## Timing
- Reset value of every output is 0: all tvalid, tdata, tlast, tkeep, tuser, both counters.
- Reset also clears all pointers, the descriptor queue and both FSMs (writer to SYNC, reader to IDLE).
- Reset mid-operation: any packet partly emitted on an output is abandoned; its tvalid is 0 in the first cycle after reset.
- Buffer RAM read latency is 1 cycle. A 2-entry output skid register keeps throughput at 1 beat/cycle while tready is high. Outputs are registered.
- Latency:
  - With the reader idle and the output ready, the first beat is valid no later than 4 cycles after the input tlast beat.
  - No bubbles within a packet while tready=1.
  - At most 2 idle cycles between back-to-back packets on the output side.
- AXIS rule: once tvalid is high, tdata/tkeep/tlast/tvalid stay stable until accepted.

## Test plan
- Control packet: 8 beats, EtherType 88B5, last tkeep 8'h0F -> identical 8 beats on m_ctrl, last tkeep 8'h0F. m_data/m_fwd tvalid stay 0. o_rx_pkt_cnt=1.
- Data packet: 64 beats, EtherType 0800, m_data_axis_tready pseudo-random at 50% -> all 64 beats delivered in order, no duplicates, stable under stall.
- Bad frame then good frame: 5-beat packet with tuser=1 on tlast, then a good 5-beat packet -> only the good packet is output. o_drop_cnt=1. Buffer occupancy returns to 0.
- Overflow: DEPTH=64, m_fwd_axis_tready=0, five 16-beat FWD packets -> packets 1–4 committed, packet 5 dropped (o_drop_cnt=1). After tready=1, four packets out in order.
- Descriptor full and runt: m_data_axis_tready=0, seventeen 2-beat data packets -> 17th dropped. Then a 1-beat packet -> dropped. o_drop_cnt=2, o_rx_pkt_cnt=16.
- Reset mid-packet on both input and output -> all outputs 0 the next cycle, counters 0. Input tail discarded until tlast or an idle cycle. The next complete packet is delivered intact.
